// File: rtl/display_pkg.sv
// Shared definitions for the display command bus: writedata field positions,
// action codes, component IDs and the dispatcher state encoding.
package display_pkg;

    localparam int unsigned COMP_MSB   = 31;
    localparam int unsigned COMP_LSB   = 26;
    localparam int unsigned CHILD_MSB  = 25;
    localparam int unsigned CHILD_LSB  = 21;
    localparam int unsigned ACT_MSB    = 20;
    localparam int unsigned ACT_LSB    = 17;
    localparam int unsigned ATYPE_MSB  = 16;
    localparam int unsigned ATYPE_LSB  = 14;
    localparam int unsigned TOGGLE_BIT = 13;
    localparam int unsigned DATA_MSB   = 12;
    localparam int unsigned DATA_LSB   = 0;

    localparam logic [3:0] ACT_UPDATE = 4'h1;
    localparam logic [3:0] ACT_TOGGLE = 4'hF;

    localparam logic [5:0] BACKGROUND_ID = 6'd1;
    localparam logic [5:0] MARIO_ID      = 6'd2;
    localparam logic [5:0] BOWSER_ID     = 6'd9;

    // Encodings are visible in the status word, so they are fixed.
    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StWaitVblank = 2'd1,
        StCommit     = 2'd2
    } disp_state_e;

    function automatic logic [31:0] commit_word(input logic [5:0] id, input logic back);
        return {id, 5'b0, ACT_TOGGLE, 3'b000, back, 13'b0};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO: o_rdata always presents the head entry.
module cmd_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/frame_cmd_dispatcher.sv
// Replays buffered software commands onto the display broadcast bus and turns
// commit commands into vblank-aligned per-component buffer toggles.
module frame_cmd_dispatcher
    import display_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned N_COMPONENTS = 12,
    parameter logic [5:0]  COMMIT_ID    = 6'b111111,
    parameter logic [9:0]  VBLANK_LINE  = 10'd480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] writedata
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    disp_state_e r_state;
    disp_state_e w_state_next;
    logic [5:0]  r_id;
    logic [5:0]  w_id_next;
    logic        r_back;
    logic [15:0] r_frame_count;
    logic        r_vbl_done;
    logic [31:0] r_writedata;
    logic [31:0] w_wd_next;
    logic [31:0] r_readdata;

    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic [4:0]    w_level5;
    logic          w_in_vblank;
    logic          w_commit_done;
    logic          w_unused_hcount;

    assign w_push          = avs_write && !w_full;
    assign avs_waitrequest = (w_level == LW'(FIFO_DEPTH));
    assign w_level5        = 5'(w_level);
    assign w_in_vblank     = (vcount >= VBLANK_LINE);
    assign w_unused_hcount = ^hcount;
    assign writedata       = r_writedata;
    assign avs_readdata    = r_readdata;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (avs_writedata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_comb begin
        w_state_next  = r_state;
        w_id_next     = r_id;
        w_wd_next     = '0;
        w_pop         = 1'b0;
        w_commit_done = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    // Commit words are consumed here; only the toggle action starts a swap.
                    if (w_head[COMP_MSB:COMP_LSB] == COMMIT_ID) begin
                        if (w_head[ACT_MSB:ACT_LSB] == ACT_TOGGLE) begin
                            w_state_next = StWaitVblank;
                        end
                    end else begin
                        w_wd_next = {w_head[COMP_MSB:ATYPE_LSB], r_back,
                                     w_head[DATA_MSB:DATA_LSB]};
                    end
                end
            end
            StWaitVblank: begin
                if (w_in_vblank && !r_vbl_done) begin
                    w_state_next = StCommit;
                    w_id_next    = 6'd1;
                end
            end
            StCommit: begin
                w_wd_next = commit_word(r_id, r_back);
                if (r_id == 6'(N_COMPONENTS)) begin
                    w_commit_done = 1'b1;
                    w_state_next  = StIdle;
                end else begin
                    w_id_next = r_id + 6'd1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_id          <= 6'd0;
            r_back        <= 1'b1;
            r_frame_count <= 16'd0;
            r_vbl_done    <= 1'b0;
            r_writedata   <= 32'd0;
            r_readdata    <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_id        <= w_id_next;
            r_writedata <= w_wd_next;
            // Once set, a further commit must wait for the next frame's vblank.
            if (w_commit_done) begin
                r_back        <= ~r_back;
                r_frame_count <= r_frame_count + 16'd1;
                r_vbl_done    <= 1'b1;
            end else if (!w_in_vblank) begin
                r_vbl_done <= 1'b0;
            end
            if (avs_read) begin
                r_readdata <= {r_frame_count, 8'b0, r_state, r_back, w_level5};
            end
        end
    end

endmodule
